dispatcher: RTL and testbench

//  Decode/rename/issue stage between the instruction queue and the back end. Decodes one RV32I instruction
//  per cycle, allocates a ROB entry, renames rd in the register file and resolves source operands.

---
 rtl/dispatcher.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_dispatcher.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatcher.sv
// Decode / rename / issue stage: decodes one RV32I instruction per cycle, allocates a ROB entry,
// renames rd, resolves operands and holds the result in a one-entry stage until the RS or LSB has room.
module dispatcher #(
    parameter int ROB_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             wrong_commit,
    input  logic             inst_valid,
    input  logic [31:0]      inst,
    input  logic [31:0]      inst_pc,
    output logic             inst_ready,
    output logic [4:0]       rf_rs1,
    output logic [4:0]       rf_rs2,
    input  logic [31:0]      rf_Vi,
    input  logic [31:0]      rf_Vj,
    input  logic [ROB_W-1:0] rf_Qi,
    input  logic [ROB_W-1:0] rf_Qj,
    output logic             rf_rename_valid,
    output logic [4:0]       rf_rename_rd,
    output logic [ROB_W-1:0] rf_rename_tag,
    input  logic             rob_full,
    input  logic [ROB_W-1:0] rob_tail,
    output logic             rob_issue_valid,
    output logic [6:0]       rob_issue_op,
    output logic [4:0]       rob_issue_rd,
    output logic [31:0]      rob_issue_pc,
    output logic [ROB_W-1:0] rob_qi,
    output logic [ROB_W-1:0] rob_qj,
    input  logic             rob_qi_ready,
    input  logic             rob_qj_ready,
    input  logic [31:0]      rob_qi_val,
    input  logic [31:0]      rob_qj_val,
    input  logic             alu_valid,
    input  logic [31:0]      alu_res,
    input  logic [ROB_W-1:0] alu_rob_id,
    input  logic             lsb_valid,
    input  logic [31:0]      lsb_res,
    input  logic [ROB_W-1:0] lsb_rob_id,
    input  logic             rs_full,
    input  logic             lsb_full,
    output logic             rs_dispatch_valid,
    output logic             lsb_dispatch_valid,
    output logic [6:0]       dispatch_op,
    output logic [31:0]      dispatch_imm,
    output logic [31:0]      dispatch_pc,
    output logic [31:0]      dispatch_Vi,
    output logic [31:0]      dispatch_Vj,
    output logic [ROB_W-1:0] dispatch_Qi,
    output logic [ROB_W-1:0] dispatch_Qj,
    output logic [ROB_W-1:0] dispatch_rd
);

    localparam logic [6:0] OP_NOP  = 7'd0,  OP_LUI  = 7'd1,  OP_AUIPC = 7'd2,  OP_JAL  = 7'd3,
                           OP_JALR = 7'd4,  OP_BEQ  = 7'd5,  OP_BNE   = 7'd6,  OP_BLT  = 7'd7,
                           OP_BGE  = 7'd8,  OP_BLTU = 7'd9,  OP_BGEU  = 7'd10, OP_LB   = 7'd11,
                           OP_LH   = 7'd12, OP_LW   = 7'd13, OP_LBU   = 7'd14, OP_LHU  = 7'd15,
                           OP_SB   = 7'd16, OP_SH   = 7'd17, OP_SW    = 7'd18, OP_ADDI = 7'd19,
                           OP_SLTI = 7'd20, OP_SLTIU= 7'd21, OP_XORI  = 7'd22, OP_ORI  = 7'd23,
                           OP_ANDI = 7'd24, OP_SLLI = 7'd25, OP_SRLI  = 7'd26, OP_SRAI = 7'd27,
                           OP_ADD  = 7'd28, OP_SUB  = 7'd29, OP_SLL   = 7'd30, OP_SLT  = 7'd31,
                           OP_SLTU = 7'd32, OP_XOR  = 7'd33, OP_SRL   = 7'd34, OP_SRA  = 7'd35,
                           OP_OR   = 7'd36, OP_AND  = 7'd37;

    localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL   = 7'b1101111,
                           OPC_JALR = 7'b1100111, OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011,
                           OPC_STORE = 7'b0100011, OPC_OPIMM = 7'b0010011, OPC_OP   = 7'b0110011;

    typedef enum logic [2:0] {FMT_X, FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

    typedef struct packed {
        logic [31:0]      v;
        logic [ROB_W-1:0] q;
    } operand_t;

    logic             stage_valid, stage_to_lsb;
    logic [6:0]       stage_op;
    logic [31:0]      stage_imm, stage_pc;
    operand_t         stage_i, stage_j;
    logic [ROB_W-1:0] stage_robid;

    logic [6:0]  dec_op;
    fmt_e        dec_fmt;
    logic        dec_to_lsb, use_rs1, use_rs2, writes_rd;
    logic [31:0] dec_imm;
    logic [2:0]  f3;
    logic        alt;
    logic        fire, accept;
    operand_t    cap_i, cap_j, pat_i, pat_j;

    assign f3     = inst[14:12];
    assign alt    = inst[30];
    assign rf_rs1 = inst[19:15];
    assign rf_rs2 = inst[24:20];

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        dec_op     = OP_NOP;
        dec_fmt    = FMT_X;
        dec_to_lsb = 1'b0;
        case (inst[6:0])
            OPC_LUI:   begin dec_op = OP_LUI;   dec_fmt = FMT_U; end
            OPC_AUIPC: begin dec_op = OP_AUIPC; dec_fmt = FMT_U; end
            OPC_JAL:   begin dec_op = OP_JAL;   dec_fmt = FMT_J; end
            OPC_JALR:  begin dec_op = (f3 == 3'd0) ? OP_JALR : OP_NOP; dec_fmt = FMT_I; end
            OPC_BRANCH: begin
                dec_fmt = FMT_B;
                case (f3)
                    3'd0: dec_op = OP_BEQ;  3'd1: dec_op = OP_BNE;
                    3'd4: dec_op = OP_BLT;  3'd5: dec_op = OP_BGE;
                    3'd6: dec_op = OP_BLTU; 3'd7: dec_op = OP_BGEU;
                    default: dec_op = OP_NOP;
                endcase
            end
            OPC_LOAD: begin
                dec_fmt    = FMT_I;
                dec_to_lsb = 1'b1;
                case (f3)
                    3'd0: dec_op = OP_LB;  3'd1: dec_op = OP_LH; 3'd2: dec_op = OP_LW;
                    3'd4: dec_op = OP_LBU; 3'd5: dec_op = OP_LHU;
                    default: dec_op = OP_NOP;
                endcase
            end
            OPC_STORE: begin
                dec_fmt    = FMT_S;
                dec_to_lsb = 1'b1;
                case (f3)
                    3'd0: dec_op = OP_SB; 3'd1: dec_op = OP_SH; 3'd2: dec_op = OP_SW;
                    default: dec_op = OP_NOP;
                endcase
            end
            OPC_OPIMM: begin
                dec_fmt = FMT_I;
                case (f3)
                    3'd0: dec_op = OP_ADDI;  3'd1: dec_op = OP_SLLI;
                    3'd2: dec_op = OP_SLTI;  3'd3: dec_op = OP_SLTIU;
                    3'd4: dec_op = OP_XORI;  3'd5: dec_op = alt ? OP_SRAI : OP_SRLI;
                    3'd6: dec_op = OP_ORI;   default: dec_op = OP_ANDI;
                endcase
            end
            OPC_OP: begin
                dec_fmt = FMT_R;
                case (f3)
                    3'd0: dec_op = alt ? OP_SUB : OP_ADD; 3'd1: dec_op = OP_SLL;
                    3'd2: dec_op = OP_SLT;  3'd3: dec_op = OP_SLTU;
                    3'd4: dec_op = OP_XOR;  3'd5: dec_op = alt ? OP_SRA : OP_SRL;
                    3'd6: dec_op = OP_OR;   default: dec_op = OP_AND;
                endcase
            end
            default: ;
        endcase
        // Anything that failed to decode travels to the RS as a plain op 0 with no operands.
        if (dec_op == OP_NOP) begin
            dec_fmt    = FMT_X;
            dec_to_lsb = 1'b0;
        end
    end

    always_comb begin
        case (dec_fmt)
            FMT_I:   dec_imm = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   dec_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   dec_imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   dec_imm = {inst[31:12], 12'd0};
            FMT_J:   dec_imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: dec_imm = 32'd0;
        endcase
    end

    assign use_rs1   = dec_fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
    assign use_rs2   = dec_fmt inside {FMT_R, FMT_S, FMT_B};
    assign writes_rd = dec_fmt inside {FMT_R, FMT_I, FMT_U, FMT_J};

    function automatic operand_t capture(input logic used, input logic [4:0] rs,
                                         input logic [31:0] rf_v, input logic [ROB_W-1:0] rf_q,
                                         input logic a_vld, input logic [31:0] a_res,
                                         input logic [ROB_W-1:0] a_id,
                                         input logic l_vld, input logic [31:0] l_res,
                                         input logic [ROB_W-1:0] l_id);
        operand_t o;
        o = '0;
        if (!used || rs == 5'd0)            o = '0;
        else if (rf_q == '0)                o.v = rf_v;
        else if (a_vld && a_id == rf_q)     o.v = a_res;
        else if (l_vld && l_id == rf_q)     o.v = l_res;
        else                                o.q = rf_q;
        return o;
    endfunction

    function automatic operand_t patch(input operand_t cur, input logic rob_rdy,
                                       input logic [31:0] rob_val,
                                       input logic a_vld, input logic [31:0] a_res,
                                       input logic [ROB_W-1:0] a_id,
                                       input logic l_vld, input logic [31:0] l_res,
                                       input logic [ROB_W-1:0] l_id);
        operand_t o;
        o = cur;
        if (cur.q != '0) begin
            if (a_vld && a_id == cur.q)      o = '{v: a_res,   q: '0};
            else if (l_vld && l_id == cur.q) o = '{v: l_res,   q: '0};
            else if (rob_rdy)                o = '{v: rob_val, q: '0};
        end
        return o;
    endfunction

    assign cap_i = capture(use_rs1, inst[19:15], rf_Vi, rf_Qi,
                           alu_valid, alu_res, alu_rob_id, lsb_valid, lsb_res, lsb_rob_id);
    assign cap_j = capture(use_rs2, inst[24:20], rf_Vj, rf_Qj,
                           alu_valid, alu_res, alu_rob_id, lsb_valid, lsb_res, lsb_rob_id);
    assign pat_i = patch(stage_i, rob_qi_ready, rob_qi_val,
                         alu_valid, alu_res, alu_rob_id, lsb_valid, lsb_res, lsb_rob_id);
    assign pat_j = patch(stage_j, rob_qj_ready, rob_qj_val,
                         alu_valid, alu_res, alu_rob_id, lsb_valid, lsb_res, lsb_rob_id);

    assign fire       = rdy & stage_valid & ~(stage_to_lsb ? lsb_full : rs_full);
    assign inst_ready = ~rst & rdy & ~wrong_commit & ~rob_full & (~stage_valid | fire);
    assign accept     = inst_valid & inst_ready;

    assign rf_rename_valid = accept & writes_rd & (inst[11:7] != 5'd0);
    assign rf_rename_rd    = rf_rename_valid ? inst[11:7] : 5'd0;
    assign rf_rename_tag   = rf_rename_valid ? rob_tail : '0;
    assign rob_issue_valid = accept;
    assign rob_issue_op    = accept ? dec_op : 7'd0;
    assign rob_issue_rd    = (accept & writes_rd) ? inst[11:7] : 5'd0;
    assign rob_issue_pc    = accept ? inst_pc : 32'd0;

    always_comb begin
        rs_dispatch_valid  = 1'b0;
        lsb_dispatch_valid = 1'b0;
        dispatch_op        = 7'd0;
        dispatch_imm       = 32'd0;
        dispatch_pc        = 32'd0;
        dispatch_Vi        = 32'd0;
        dispatch_Vj        = 32'd0;
        dispatch_Qi        = '0;
        dispatch_Qj        = '0;
        dispatch_rd        = '0;
        rob_qi             = '0;
        rob_qj             = '0;
        if (stage_valid) begin
            rs_dispatch_valid  = fire & ~stage_to_lsb;
            lsb_dispatch_valid = fire & stage_to_lsb;
            dispatch_op        = stage_op;
            dispatch_imm       = stage_imm;
            dispatch_pc        = stage_pc;
            dispatch_Vi        = pat_i.v;
            dispatch_Vj        = pat_j.v;
            dispatch_Qi        = pat_i.q;
            dispatch_Qj        = pat_j.q;
            dispatch_rd        = stage_robid;
            rob_qi             = stage_i.q;
            rob_qj             = stage_j.q;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst || wrong_commit) begin
            stage_valid <= 1'b0;
        end else if (rdy) begin
            if (accept)    stage_valid <= 1'b1;
            else if (fire) stage_valid <= 1'b0;
        end
    end

    // NOTE: the payload needs no reset; stage_valid alone qualifies it and gates every output.
    always_ff @(posedge clk) begin
        if (rdy) begin
            if (accept) begin
                stage_op     <= dec_op;
                stage_imm    <= dec_imm;
                stage_pc     <= inst_pc;
                stage_i      <= cap_i;
                stage_j      <= cap_j;
                stage_robid  <= rob_tail;
                stage_to_lsb <= dec_to_lsb;
            end else if (stage_valid && !fire) begin
                stage_i <= pat_i;
                stage_j <= pat_j;
            end
        end
    end

endmodule

// File: tb/tb_dispatcher.sv
// Randomised bench for dispatcher: instructions are built by an encoder that knows the expected
// decode, and a stage-level model predicts rename, issue and dispatch outputs every cycle.
module tb_dispatcher;

    logic        clk, rst, rdy, wrong_commit, inst_valid, inst_ready;
    logic [31:0] inst, inst_pc, rf_Vi, rf_Vj;
    logic [4:0]  rf_rs1, rf_rs2, rf_Qi, rf_Qj, rf_rename_rd, rf_rename_tag, rob_tail;
    logic        rf_rename_valid, rob_full, rob_issue_valid;
    logic [6:0]  rob_issue_op, dispatch_op;
    logic [4:0]  rob_issue_rd, rob_qi, rob_qj, alu_rob_id, lsb_rob_id;
    logic [31:0] rob_issue_pc, rob_qi_val, rob_qj_val, alu_res, lsb_res;
    logic        rob_qi_ready, rob_qj_ready, alu_valid, lsb_valid, rs_full, lsb_full;
    logic        rs_dispatch_valid, lsb_dispatch_valid;
    logic [31:0] dispatch_imm, dispatch_pc, dispatch_Vi, dispatch_Vj;
    logic [4:0]  dispatch_Qi, dispatch_Qj, dispatch_rd;

    dispatcher #(.ROB_W(5)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .wrong_commit(wrong_commit),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_Vi(rf_Vi), .rf_Vj(rf_Vj), .rf_Qi(rf_Qi), .rf_Qj(rf_Qj),
        .rf_rename_valid(rf_rename_valid), .rf_rename_rd(rf_rename_rd), .rf_rename_tag(rf_rename_tag),
        .rob_full(rob_full), .rob_tail(rob_tail), .rob_issue_valid(rob_issue_valid),
        .rob_issue_op(rob_issue_op), .rob_issue_rd(rob_issue_rd), .rob_issue_pc(rob_issue_pc),
        .rob_qi(rob_qi), .rob_qj(rob_qj), .rob_qi_ready(rob_qi_ready), .rob_qj_ready(rob_qj_ready),
        .rob_qi_val(rob_qi_val), .rob_qj_val(rob_qj_val),
        .alu_valid(alu_valid), .alu_res(alu_res), .alu_rob_id(alu_rob_id),
        .lsb_valid(lsb_valid), .lsb_res(lsb_res), .lsb_rob_id(lsb_rob_id),
        .rs_full(rs_full), .lsb_full(lsb_full),
        .rs_dispatch_valid(rs_dispatch_valid), .lsb_dispatch_valid(lsb_dispatch_valid),
        .dispatch_op(dispatch_op), .dispatch_imm(dispatch_imm), .dispatch_pc(dispatch_pc),
        .dispatch_Vi(dispatch_Vi), .dispatch_Vj(dispatch_Vj),
        .dispatch_Qi(dispatch_Qi), .dispatch_Qj(dispatch_Qj), .dispatch_rd(dispatch_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum {F_R, F_I, F_SH, F_S, F_B, F_U, F_J, F_X} fmt_t;

    typedef struct {
        logic        valid, lsb;
        logic [6:0]  op;
        logic [31:0] imm, pc, vi, vj;
        logic [4:0]  qi, qj, rd;
    } stage_t;

    stage_t      m;
    int          n_vec, n_err;
    logic [6:0]  cur_op;
    logic [31:0] cur_imm;
    logic [4:0]  cur_rd, cur_rs1;
    logic        cur_use1, cur_use2, cur_wr, cur_lsb;

    logic [2:0] br_f3 [6]  = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [2:0] ld_f3 [5]  = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [2:0] ia_f3 [6]  = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
    logic [2:0] r_f3  [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Build an instruction of internal op k from fields; the expected decode follows by construction.
    task automatic gen_inst(input int k, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [31:0] r);
        fmt_t f;
        logic [6:0] opc;
        logic [2:0] fn3;
        logic b30;
        f = F_X; opc = 7'h7b; fn3 = r[14:12]; b30 = 1'b0;
        if (k == 1)                   begin f = F_U; opc = 7'h37; end
        else if (k == 2)              begin f = F_U; opc = 7'h17; end
        else if (k == 3)              begin f = F_J; opc = 7'h6f; end
        else if (k == 4)              begin f = F_I; opc = 7'h67; fn3 = 3'd0; end
        else if (k >= 5 && k <= 10)   begin f = F_B; opc = 7'h63; fn3 = br_f3[k-5]; end
        else if (k >= 11 && k <= 15)  begin f = F_I; opc = 7'h03; fn3 = ld_f3[k-11]; end
        else if (k >= 16 && k <= 18)  begin f = F_S; opc = 7'h23; fn3 = 3'(k - 16); end
        else if (k >= 19 && k <= 24)  begin f = F_I; opc = 7'h13; fn3 = ia_f3[k-19]; end
        else if (k >= 25 && k <= 27)  begin
            f = F_SH; opc = 7'h13; fn3 = (k == 25) ? 3'd1 : 3'd5; b30 = (k == 27);
        end else if (k >= 28 && k <= 37) begin
            f = F_R; opc = 7'h33; fn3 = r_f3[k-28]; b30 = (k == 29 || k == 35);
        end
        case (f)
            F_R:  begin inst = {1'b0, b30, 5'd0, rs2, rs1, fn3, rd, opc}; cur_imm = 32'd0; end
            F_I:  begin inst = {r[11:0], rs1, fn3, rd, opc}; cur_imm = {{20{r[11]}}, r[11:0]}; end
            F_SH: begin
                inst = {1'b0, b30, 5'd0, r[4:0], rs1, fn3, rd, opc};
                cur_imm = {21'd0, b30, 5'd0, r[4:0]};
            end
            F_S:  begin
                inst = {r[11:5], rs2, rs1, fn3, r[4:0], opc};
                cur_imm = {{20{r[11]}}, r[11:0]};
            end
            F_B:  begin
                inst = {r[12], r[10:5], rs2, rs1, fn3, r[4:1], r[11], opc};
                cur_imm = {{19{r[12]}}, r[12:1], 1'b0};
            end
            F_U:  begin inst = {r[31:12], rd, opc}; cur_imm = {r[31:12], 12'd0}; end
            F_J:  begin
                inst = {r[20], r[10:1], r[11], r[19:12], rd, opc};
                cur_imm = {{11{r[20]}}, r[20:1], 1'b0};
            end
            default: begin inst = {r[31:7], opc}; cur_imm = 32'd0; end
        endcase
        cur_op   = 7'(k);
        cur_rd   = rd;
        cur_rs1  = rs1;
        cur_use1 = f inside {F_R, F_I, F_SH, F_S, F_B};
        cur_use2 = f inside {F_R, F_S, F_B};
        cur_wr   = f inside {F_R, F_I, F_SH, F_U, F_J};
        cur_lsb  = (k >= 11 && k <= 18);
    endtask

    function automatic void resolve(input logic used, input logic [4:0] rs, input logic [31:0] v,
                                    input logic [4:0] q, output logic [31:0] vo, output logic [4:0] qo);
        vo = 32'd0; qo = 5'd0;
        if (!used || rs == 5'd0) ;
        else if (q == 5'd0)                       vo = v;
        else if (alu_valid && alu_rob_id == q)    vo = alu_res;
        else if (lsb_valid && lsb_rob_id == q)    vo = lsb_res;
        else                                      qo = q;
    endfunction

    function automatic void patch(input logic [4:0] q, input logic [31:0] v, input logic rr,
                                  input logic [31:0] rv, output logic [4:0] qo, output logic [31:0] vo);
        qo = q; vo = v;
        if (q != 5'd0) begin
            if (alu_valid && alu_rob_id == q)      begin vo = alu_res; qo = 5'd0; end
            else if (lsb_valid && lsb_rob_id == q) begin vo = lsb_res; qo = 5'd0; end
            else if (rr)                           begin vo = rv;      qo = 5'd0; end
        end
    endfunction

    // One cycle: predict and compare at the falling edge, advance the model at the rising edge.
    task automatic step();
        logic fire_m, ready_m, acc, ren;
        logic [31:0] pvi, pvj, cvi, cvj;
        logic [4:0]  pqi, pqj, cqi, cqj;
        @(negedge clk);
        fire_m  = rdy && m.valid && !(m.lsb ? lsb_full : rs_full);
        ready_m = !rst && rdy && !wrong_commit && !rob_full && (!m.valid || fire_m);
        acc     = inst_valid && ready_m;
        ren     = acc && cur_wr && cur_rd != 5'd0;
        patch(m.qi, m.vi, rob_qi_ready, rob_qi_val, pqi, pvi);
        patch(m.qj, m.vj, rob_qj_ready, rob_qj_val, pqj, pvj);
        resolve(cur_use1, inst[19:15], rf_Vi, rf_Qi, cvi, cqi);
        resolve(cur_use2, inst[24:20], rf_Vj, rf_Qj, cvj, cqj);

        check("inst_ready", inst_ready, ready_m);
        check("rob_issue_valid", rob_issue_valid, acc);
        check("rename_valid", rf_rename_valid, ren);
        if (cur_use1) check("rf_rs1", rf_rs1, cur_rs1);
        if (ren) begin
            check("rename_rd", rf_rename_rd, cur_rd);
            check("rename_tag", rf_rename_tag, rob_tail);
        end
        if (acc) begin
            check("issue_op", rob_issue_op, cur_op);
            check("issue_rd", rob_issue_rd, cur_wr ? cur_rd : 5'd0);
            check("issue_pc", rob_issue_pc, inst_pc);
        end
        check("rs_strobe", rs_dispatch_valid, fire_m && !m.lsb);
        check("lsb_strobe", lsb_dispatch_valid, fire_m && m.lsb);
        if (m.valid) begin
            check("disp_op", dispatch_op, m.op);
            check("disp_imm", dispatch_imm, m.imm);
            check("disp_pc", dispatch_pc, m.pc);
            check("disp_rd", dispatch_rd, m.rd);
            check("disp_Qi", dispatch_Qi, pqi);
            check("disp_Qj", dispatch_Qj, pqj);
            if (pqi == 5'd0) check("disp_Vi", dispatch_Vi, pvi);
            if (pqj == 5'd0) check("disp_Vj", dispatch_Vj, pvj);
            check("rob_qi", rob_qi, m.qi);
            check("rob_qj", rob_qj, m.qj);
        end else begin
            check("idle_op", dispatch_op, 7'd0);
            check("idle_imm", dispatch_imm, 32'd0);
            check("idle_Vi", dispatch_Vi, 32'd0);
            check("idle_Qj", dispatch_Qj, 5'd0);
            check("idle_rd", dispatch_rd, 5'd0);
            check("idle_rob_qi", rob_qi, 5'd0);
        end

        @(posedge clk);
        if (rst || wrong_commit) m.valid = 1'b0;
        else if (rdy) begin
            if (acc) begin
                m.valid = 1'b1; m.op = cur_op; m.imm = cur_imm; m.pc = inst_pc;
                m.vi = cvi; m.qi = cqi; m.vj = cvj; m.qj = cqj; m.rd = rob_tail; m.lsb = cur_lsb;
            end else if (fire_m) m.valid = 1'b0;
            else if (m.valid) begin
                m.vi = pvi; m.qi = pqi; m.vj = pvj; m.qj = pqj;
            end
        end
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; rdy = 1'b1; wrong_commit = 1'b0; inst_valid = 1'b0; inst_pc = 32'd0;
        rob_full = 1'b0; rob_tail = 5'd1; rs_full = 1'b0; lsb_full = 1'b0;
        rf_Vi = 32'd0; rf_Vj = 32'd0; rf_Qi = 5'd0; rf_Qj = 5'd0;
        alu_valid = 1'b0; alu_res = 32'd0; alu_rob_id = 5'd0;
        lsb_valid = 1'b0; lsb_res = 32'd0; lsb_rob_id = 5'd0;
        rob_qi_ready = 1'b0; rob_qj_ready = 1'b0; rob_qi_val = 32'd0; rob_qj_val = 32'd0;
        gen_inst(0, 5'd0, 5'd0, 5'd0, 32'd0);
    endtask

    function automatic logic [4:0] rnd_reg();
        return ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    endfunction

    task automatic rand_inputs();
        int k;
        k = $urandom_range(0, 37);
        gen_inst(k, rnd_reg(), rnd_reg(), rnd_reg(), $urandom());
        inst_pc      = $urandom();
        inst_valid   = $urandom_range(0, 9) < 8;
        rdy          = $urandom_range(0, 9) != 0;
        wrong_commit = $urandom_range(0, 39) == 0;
        rst          = $urandom_range(0, 199) == 0;
        rob_full     = $urandom_range(0, 9) == 0;
        rs_full      = $urandom_range(0, 3) == 0;
        lsb_full     = $urandom_range(0, 3) == 0;
        rob_tail     = 5'($urandom_range(1, 31));
        rf_Vi = $urandom(); rf_Vj = $urandom();
        rf_Qi = 5'($urandom_range(0, 7)); rf_Qj = 5'($urandom_range(0, 7));
        alu_valid = 1'($urandom_range(0, 1)); alu_res = $urandom(); alu_rob_id = 5'($urandom_range(1, 7));
        lsb_valid = 1'($urandom_range(0, 1)); lsb_res = $urandom(); lsb_rob_id = 5'($urandom_range(1, 7));
        rob_qi_ready = $urandom_range(0, 3) == 0; rob_qi_val = $urandom();
        rob_qj_ready = $urandom_range(0, 3) == 0; rob_qj_val = $urandom();
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        m.valid = 1'b0;
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        inst_valid = 1'b1;
        step();

        // ADDI x1,x0,5 into an empty machine
        idle(); gen_inst(19, 5'd1, 5'd0, 5'd0, 32'd5); inst_valid = 1'b1; #1;
        check("t1_inst_rs1", {27'd0, rf_rs1}, 32'd0);
        check("t1_rename_rd", rf_rename_rd, 32'd1);
        check("t1_issue_rd", rob_issue_rd, 32'd1);
        step();
        idle(); #1;
        check("t1_rs_strobe", rs_dispatch_valid, 32'd1);
        check("t1_op", dispatch_op, 32'd19);
        check("t1_imm", dispatch_imm, 32'd5);
        check("t1_rd", dispatch_rd, 32'd1);
        step();

        // ADD x3,x1,x2 waits on tag 3 behind a full RS; ALU resolves it while held
        idle(); gen_inst(28, 5'd3, 5'd1, 5'd2, 32'd0); inst_valid = 1'b1; rf_Qi = 5'd3; rf_Vj = 32'd7; rob_tail = 5'd2;
        step();
        idle(); rs_full = 1'b1; step();
        idle(); rs_full = 1'b1; alu_valid = 1'b1; alu_rob_id = 5'd3; alu_res = 32'h10; inst_valid = 1'b1; #1;
        check("t2_ready_held", inst_ready, 32'd0);
        step();
        idle(); rs_full = 1'b1; step();
        idle(); #1;
        check("t2_Vi", dispatch_Vi, 32'h10);
        check("t2_Qi", dispatch_Qi, 32'd0);
        check("t2_strobe", rs_dispatch_valid, 32'd1);
        step();

        // operand resolved by an LSB broadcast in the dispatch cycle itself
        idle(); gen_inst(28, 5'd5, 5'd0, 5'd6, 32'd0); inst_valid = 1'b1; rf_Qj = 5'd4; rob_tail = 5'd3;
        step();
        idle(); lsb_valid = 1'b1; lsb_rob_id = 5'd4; lsb_res = 32'hABCD; #1;
        check("t3_Vj", dispatch_Vj, 32'hABCD);
        check("t3_Qj", dispatch_Qj, 32'd0);
        step();

        // LW x2,8(x1) blocked by a full LSB
        idle(); gen_inst(13, 5'd2, 5'd1, 5'd0, 32'd8); inst_valid = 1'b1; #1;
        check("t4_inst", inst, 32'h0080A103);
        step();
        idle(); lsb_full = 1'b1; inst_valid = 1'b1; #1;
        check("t4_no_strobe", lsb_dispatch_valid, 32'd0);
        check("t4_not_ready", inst_ready, 32'd0);
        step();
        idle(); #1;
        check("t4_lsb_strobe", lsb_dispatch_valid, 32'd1);
        check("t4_rs_strobe", rs_dispatch_valid, 32'd0);
        check("t4_imm", dispatch_imm, 32'd8);
        step();

        // flush with a valid stage and a waiting instruction
        idle(); gen_inst(19, 5'd4, 5'd0, 5'd0, 32'd1); inst_valid = 1'b1; step();
        idle(); gen_inst(19, 5'd5, 5'd0, 5'd0, 32'd2); inst_valid = 1'b1; wrong_commit = 1'b1; #1;
        check("t5_ready", inst_ready, 32'd0);
        check("t5_issue", rob_issue_valid, 32'd0);
        check("t5_rename", rf_rename_valid, 32'd0);
        step();
        idle(); #1;
        check("t5_no_dispatch", rs_dispatch_valid, 32'd0);
        step();

        // ROB full, then back-to-back accepts
        idle(); gen_inst(33, 5'd7, 5'd1, 5'd2, 32'd0); inst_valid = 1'b1; rob_full = 1'b1; #1;
        check("t6_ready", inst_ready, 32'd0);
        check("t6_issue", rob_issue_valid, 32'd0);
        check("t6_rename", rf_rename_valid, 32'd0);
        step();
        for (int i = 0; i < 4; i++) begin
            idle(); gen_inst(19 + i, 5'(8 + i), 5'd0, 5'd0, 32'(i)); inst_valid = 1'b1; rob_tail = 5'(4 + i); #1;
            check("t6_b2b_ready", inst_ready, 32'd1);
            step();
        end

        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
